// File: rtl/discrete_value_sampler.sv
// Requests a [start,end] range from the discrete range randomizer and draws a uniform value
// inside it by LFSR rejection sampling. SAMPLER_STATS_EN adds retry/fallback counters.
module discrete_value_sampler #(
  parameter int unsigned MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 4,
  parameter int unsigned MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 2,
  parameter int unsigned RANGE_LATENCY                     = 3,
  parameter int unsigned MAX_RETRIES                       = 8
) (
  input  logic                                        in_clock,
  input  logic                                        in_reset,
  input  logic                                        in_seed_load,
  input  logic [15:0]                                 in_seed,
  input  logic                                        in_request_valid,
  output logic                                        out_request_ready,
  input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] in_request_index,
  output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] out_variable_index,
  output logic                                        out_random_enable,
  output logic                                        out_table_enable,
  input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_start,
  input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_end,
  input  logic                                        in_equal,
  output logic                                        out_value_valid,
  input  logic                                        in_value_ready,
  output logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_value,
  output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] out_value_index,
  output logic                                        out_fallback,
`ifdef SAMPLER_STATS_EN
  output logic [15:0]                                 out_retry_total,
  output logic [15:0]                                 out_fallback_total,
`endif
  output logic                                        out_range_error
);

  localparam int unsigned W      = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int unsigned IDX    = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
  localparam int unsigned CntW   = (RANGE_LATENCY > 1) ? $clog2(RANGE_LATENCY) : 1;
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
  localparam logic [15:0] SeedDefault = 16'hACE1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StSample, StOutput} state_e;

  state_e            state_q, state_d;
  logic [IDX-1:0]    idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      start_q, start_d;
  logic [W-1:0]      span_q, span_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [W-1:0]      value_q, value_d;
  logic              fallback_q, fallback_d;
  logic              error_q, error_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              reject, fb_event;
  logic [W-1:0]      cand;

  // Smallest all-ones mask covering v.
  function automatic logic [W-1:0] smear(input logic [W-1:0] v);
    logic [W-1:0] m;
    m = v;
    for (int i = 1; i < W; i++) m = m | (v >> i);
    return m;
  endfunction

  assign cand = lfsr_q[W-1:0] & smear(span_q);

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    cnt_d             = cnt_q;
    start_d           = start_q;
    span_d            = span_q;
    retry_d           = retry_q;
    value_d           = value_q;
    fallback_d        = fallback_q;
    error_d           = error_q;
    lfsr_d            = lfsr_q;
    reject            = 1'b0;
    fb_event          = 1'b0;
    out_request_ready = 1'b0;
    out_random_enable = 1'b0;
    out_table_enable  = 1'b0;
    out_value_valid   = 1'b0;
    unique case (state_q)
      StIdle: begin
        out_request_ready = 1'b1;
        if (in_request_valid) begin
          idx_d   = in_request_index;
          state_d = StIssue;
        end
      end
      StIssue: begin
        out_random_enable = 1'b1;
        out_table_enable  = 1'b1;
        cnt_d             = CntW'(RANGE_LATENCY - 1);
        state_d           = StWait;
      end
      StWait: begin
        out_table_enable = 1'b1;
        if (cnt_q == '0) begin
          start_d = in_start;
          if (in_equal) begin
            value_d    = in_start;
            fallback_d = 1'b0;
            error_d    = 1'b0;
            state_d    = StOutput;
          end else if (in_start > in_end) begin
            value_d = in_start;
            error_d = 1'b1;
            state_d = StOutput;
          end else begin
            span_d  = in_end - in_start;
            retry_d = '0;
            state_d = StSample;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSample: begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (cand <= span_q) begin
          value_d = start_q + cand;
          state_d = StOutput;
        end else begin
          reject  = 1'b1;
          retry_d = retry_q + RetryW'(1);
          if (retry_q == RetryW'(MAX_RETRIES - 1)) begin
            value_d    = start_q;
            fallback_d = 1'b1;
            fb_event   = 1'b1;
            state_d    = StOutput;
          end
        end
      end
      StOutput: begin
        out_value_valid = 1'b1;
        if (in_value_ready) begin
          fallback_d = 1'b0;
          error_d    = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A seed load overrides the SAMPLE step.
    if (in_seed_load) lfsr_d = (in_seed == 16'h0000) ? SeedDefault : in_seed;
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      start_q    <= '0;
      span_q     <= '0;
      retry_q    <= '0;
      value_q    <= '0;
      fallback_q <= 1'b0;
      error_q    <= 1'b0;
      lfsr_q     <= SeedDefault;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      span_q     <= span_d;
      retry_q    <= retry_d;
      value_q    <= value_d;
      fallback_q <= fallback_d;
      error_q    <= error_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign out_variable_index = idx_q;
  assign out_value_index    = idx_q;
  assign out_value          = value_q;
  assign out_fallback       = fallback_q;
  assign out_range_error    = error_q;

`ifdef SAMPLER_STATS_EN
  logic [15:0] retry_total_q, fallback_total_q;

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      retry_total_q    <= '0;
      fallback_total_q <= '0;
    end else begin
      if (reject && retry_total_q != 16'hFFFF) retry_total_q <= retry_total_q + 16'd1;
      if (fb_event && fallback_total_q != 16'hFFFF) begin
        fallback_total_q <= fallback_total_q + 16'd1;
      end
    end
  end

  assign out_retry_total    = retry_total_q;
  assign out_fallback_total = fallback_total_q;
`endif

endmodule

// File: doc/discrete_value_sampler.md
Name: discrete_value_sampler

Overview:
- Downstream consumer of the discrete range randomizer, which provides a variable index and returns a chosen [start,end] range.
- Sequences one request: drives the variable index and enables, waits a fixed latency, captures start/end, then draws a uniform integer within the range.
- Draws by rejection sampling on an internal 16-bit LFSR.
- The sampled value goes to the MCMC proposal stage over a valid/ready handshake.

Parameters:
- MAX_BIT_WIDTH_OF_INTEGER_VARIABLE, 4, width W of start/end/value; legal range 1..16.
- MAX_BIT_WIDTH_OF_VARIABLES_INDEX, 2, width of the variable index.
- RANGE_LATENCY, 3, number of WAIT cycles from enable issue to valid in_start/in_end; minimum 1.
- MAX_RETRIES, 8, maximum candidates drawn before fallback; minimum 1.

Ports:
- in_clock, input, 1, clock.
- in_reset, input, 1, asynchronous active-high reset.
- in_seed_load, input, 1, loads in_seed into the LFSR.
- in_seed, input, 16, LFSR seed.
- in_request_valid, input, 1, request present.
- out_request_ready, output, 1, high only in IDLE.
- in_request_index, input, IDX, variable to sample.
- out_variable_index, output, IDX, registered index driven to the randomizer.
- out_random_enable, output, 1, one-cycle pulse to the randomizer's random generator.
- out_table_enable, output, 1, read enable to both randomizer tables.
- in_start, input, W, range start from the randomizer.
- in_end, input, W, range end from the randomizer.
- in_equal, input, 1, start==end from the randomizer.
- out_value_valid, output, 1, result valid.
- in_value_ready, input, 1, consumer accepts.
- out_value, output, W, sampled value.
- out_value_index, output, IDX, index that the value belongs to.
- out_fallback, output, 1, retries exhausted; value forced to start.
- out_range_error, output, 1, captured start>end.

Behaviour:
- Reset (async, any state): state=IDLE, LFSR=16'hACE1. All outputs 0 except out_request_ready=1.
- States: IDLE, ISSUE, WAIT, SAMPLE, OUTPUT.
- IDLE:
  - On in_request_valid&&out_request_ready at edge t: register index, go to ISSUE.
- ISSUE (cycle t+1):
  - out_random_enable=1 (this cycle only), out_table_enable=1.
  - Load wait counter with RANGE_LATENCY-1; go to WAIT.
- WAIT:
  - out_table_enable=1; counter decrements.
  - At counter==0: capture in_start, in_end, in_equal.
  - Branch on the captured values:
    - in_equal=1: value=start, fallback=0, error=0, go to OUTPUT.
    - start>end (unsigned): value=start, error=1, go to OUTPUT.
    - otherwise: span=end-start, clear retry count, go to SAMPLE.
- Mask rule: mask = smallest 2^k-1 >= span (OR-smear of span). candidate = LFSR[W-1:0] & mask.
- SAMPLE, one candidate per cycle:
  - The LFSR steps every SAMPLE cycle.
  - candidate<=span: value=start+candidate (W-bit, cannot overflow), go to OUTPUT.
  - Else retry+1. If retry reaches MAX_RETRIES: value=start, fallback=1, go to OUTPUT.
- OUTPUT:
  - out_value_valid=1; value, index and flags held stable until in_value_ready.
  - Transfer on valid&&ready → IDLE.
  - Flags (fallback, error) clear on leaving OUTPUT.
- Latency from accept edge t:
  - equal/error ranges: out_value_valid at cycle t+2+RANGE_LATENCY.
  - first candidate accepted: t+3+RANGE_LATENCY.
- LFSR:
  - Fibonacci, taps 16,14,13,11; steps only in SAMPLE.
  - in_seed_load wins over a step in the same cycle. A zero seed is replaced with 16'hACE1.
- in_request_valid outside IDLE is ignored (no ready). Randomizer outputs are ignored outside the capture cycle.
- Reset mid-operation discards the pending request; no partial output.

Optional Feature:
- SAMPLER_STATS_EN defined:
  - Adds out_retry_total (16-bit) and out_fallback_total (16-bit) outputs.
  - out_retry_total counts rejected candidates; out_fallback_total counts fallbacks.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: no counters, ports absent; core behaviour identical.

Test Plan:
- Reset, then request index 1 with start=5, end=5, equal=1 (L=3) → valid at t+5, value=5, fallback=0, error=0, index=1; enables seen at t+1 (random pulse) and t+1..t+4 (table).
- Seed 16'h0001, range [2,9] (span 7, mask 7), run 200 requests → every value within 2..9, all 8 values occur, never fallback.
- Range [0,8] (span 8, mask 15), MAX_RETRIES=1, seed chosen so LFSR[3:0]=12 → value=0, fallback=1.
- start=9, end=3 → value=9, error=1, no SAMPLE cycles.
- Hold in_value_ready=0 for 10 cycles in OUTPUT → value/flags stable, out_request_ready=0; new in_request_valid ignored until transfer.
- Assert in_reset during WAIT → outputs zero immediately, ready=1; the next request completes normally. With SAMPLER_STATS_EN, check counters clear on reset.
